// File: rtl/spi_dbg_if.sv
// Byte-level link between the SPI slave shifter and the debug engine.
interface spi_dbg_if;
  logic [7:0] recv_data;
  logic       recv_ready;
  logic [7:0] send_data;

  modport master (output recv_data, output recv_ready, input send_data);
  modport slave  (input recv_data, input recv_ready, output send_data);
endinterface

// File: rtl/spi_dbg_engine.sv
// SPI-driven debug engine: byte command decoder, core clock gating/stepping,
// and PC / register / fetched-instruction snapshot readback.
module spi_dbg_engine #(
  parameter int XLEN        = 64,
  parameter int INSTR_BYTES = 14,
  parameter int REG_SEL_W   = 5,
  parameter int STEP_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  spi_dbg_if.slave                 spi,
  input  logic [XLEN-1:0]          reg_pc,
  input  logic [8*INSTR_BYTES-1:0] fetch_instr,
  output logic [REG_SEL_W-1:0]     reg_read_sel,
  input  logic [XLEN-1:0]          reg_read_data,
  output logic                     core_clk_enable,
  output logic                     led
);

  localparam int SNAP_W     = (XLEN > 8*INSTR_BYTES) ? XLEN : 8*INSTR_BYTES;
  localparam int STEP_BYTES = STEP_W / 8;

  typedef enum logic [2:0] {IDLE, ECHO, REG_SEL, REG_WAIT, STEP_CNT, REPLY} state_t;

  state_t              state;
  logic [SNAP_W-1:0]   snap;
  logic [7:0]          reply_left;
  logic [STEP_W-1:0]   step_acc;
  logic [STEP_W-1:0]   step_nxt;
  logic [STEP_W-1:0]   step_cnt;
  logic [1:0]          byte_idx;
  logic                free_run;

  always_comb begin
    step_nxt = (step_acc << 8) | STEP_W'(spi.recv_data);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      spi.send_data   <= '0;
      reg_read_sel    <= '0;
      led             <= 1'b0;
      free_run        <= 1'b1;
      step_cnt        <= '0;
      core_clk_enable <= 1'b1;
      snap            <= '0;
      reply_left      <= '0;
      step_acc        <= '0;
      byte_idx        <= '0;
    end else begin
      // Enable tracks the post-edge counter value, so a load of N yields N cycles.
      if (step_cnt != '0) step_cnt <= step_cnt - 1'b1;
      core_clk_enable <= free_run | (step_cnt > STEP_W'(1));

      case (state)
        IDLE: if (spi.recv_ready) begin
          spi.send_data <= 8'h00;
          case (spi.recv_data)
            8'h00: ;
            8'h01: begin spi.send_data <= 8'h01; state <= ECHO; end
            8'h02: led <= ~led;
            8'h03: begin
              free_run        <= 1'b1;
              step_cnt        <= '0;
              core_clk_enable <= 1'b1;
            end
            8'h04: begin
              free_run        <= 1'b0;
              step_cnt        <= '0;
              core_clk_enable <= 1'b0;
            end
            8'h05: begin byte_idx <= '0; state <= STEP_CNT; end
            8'h06: begin
              snap       <= SNAP_W'(reg_pc) << (SNAP_W - XLEN);
              reply_left <= 8'(XLEN/8);
              state      <= REPLY;
            end
            8'h07: state <= REG_SEL;
            8'h09: begin
              snap       <= SNAP_W'(fetch_instr) << (SNAP_W - 8*INSTR_BYTES);
              reply_left <= 8'(INSTR_BYTES);
              state      <= REPLY;
            end
            8'h0A: spi.send_data <= {6'b0, step_cnt != '0, free_run};
            8'hCC: spi.send_data <= 8'hCC;
            default: spi.send_data <= 8'hFF;
          endcase
        end
        ECHO: if (spi.recv_ready) begin
          spi.send_data <= spi.recv_data;
          state         <= IDLE;
        end
        REG_SEL: if (spi.recv_ready) begin
          reg_read_sel  <= spi.recv_data[REG_SEL_W-1:0];
          spi.send_data <= 8'h00;
          state         <= REG_WAIT;
        end
        REG_WAIT: begin
          snap       <= SNAP_W'(reg_read_data) << (SNAP_W - XLEN);
          reply_left <= 8'(XLEN/8);
          state      <= REPLY;
        end
        STEP_CNT: if (spi.recv_ready) begin
          spi.send_data <= 8'h00;
          step_acc      <= step_nxt;
          if (byte_idx == 2'(STEP_BYTES-1)) begin
            step_cnt        <= step_nxt;
            core_clk_enable <= free_run | (step_nxt != '0);
            state           <= IDLE;
          end else begin
            byte_idx <= byte_idx + 1'b1;
          end
        end
        REPLY: if (spi.recv_ready) begin
          spi.send_data <= snap[SNAP_W-1 -: 8];
          snap          <= snap << 8;
          reply_left    <= reply_left - 1'b1;
          if (reply_left == 8'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_dbg_engine.sv
// Scoreboard bench for spi_dbg_engine: directed byte streams, expected replies queued.
module tb_spi_dbg_engine;
  localparam int XLEN = 64;
  localparam int IB   = 14;
  localparam int RW   = 5;
  localparam int SW   = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_dbg_if ifc();
  logic [XLEN-1:0] reg_pc;
  logic [8*IB-1:0] fetch_instr;
  logic [RW-1:0]   reg_read_sel;
  logic [XLEN-1:0] reg_read_data;
  logic            core_clk_enable;
  logic            led;

  // Register file model: only r3 holds the interesting value.
  assign reg_read_data = (reg_read_sel == 5'd3) ? 64'h00000000DEADBEEF
                                                : (64'h0BAD000000000000 | 64'(reg_read_sel));

  spi_dbg_engine #(.XLEN(XLEN), .INSTR_BYTES(IB), .REG_SEL_W(RW), .STEP_W(SW)) dut (
    .clk(clk), .rst(rst), .spi(ifc.slave), .reg_pc(reg_pc), .fetch_instr(fetch_instr),
    .reg_read_sel(reg_read_sel), .reg_read_data(reg_read_data),
    .core_clk_enable(core_clk_enable), .led(led)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  logic strobe_d;

  always @(posedge clk or posedge rst)
    if (rst) strobe_d <= 1'b0;
    else     strobe_d <= ifc.recv_ready;

  always @(negedge clk) begin : monitor
    logic [7:0] e;
    if (strobe_d) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL send_data: got %02h, no reply expected", ifc.send_data);
      end else begin
        e = exp_q.pop_front();
        if (ifc.send_data !== e) begin
          bad++;
          $display("FAIL send_data: got %02h expected %02h", ifc.send_data, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic [7:0] e);
    gap(2);
    exp_q.push_back(e);
    ifc.recv_data  = b;
    ifc.recv_ready = 1'b1;
    @(negedge clk);
    ifc.recv_ready = 1'b0;
  endtask

  logic [63:0] pc_val;

  initial begin
    rst = 1'b1;
    ifc.recv_ready = 1'b0;
    ifc.recv_data  = 8'h00;
    pc_val = 64'h0123456789ABCDEF;
    reg_pc = pc_val;
    for (int i = 0; i < IB; i++) fetch_instr[8*(IB-1-i) +: 8] = 8'(8'h10 + i);
    gap(3);
    check("rst_send_data", 64'(ifc.send_data), 64'h00);
    check("rst_clk_en", 64'(core_clk_enable), 64'h1);
    check("rst_led", 64'(led), 64'h0);
    check("rst_reg_sel", 64'(reg_read_sel), 64'h0);
    rst = 1'b0;
    gap(2);

    // Echo then NOP
    send(8'h01, 8'h01);
    send(8'h5A, 8'h5A);
    send(8'h00, 8'h00);

    // LED toggle and status
    send(8'h02, 8'h00);
    check("led_on", 64'(led), 64'h1);
    send(8'h02, 8'h00);
    check("led_off", 64'(led), 64'h0);
    send(8'h0A, 8'h01);

    // Stop free-run, step 3 cycles
    send(8'h04, 8'h00);
    gap(2);
    check("halted", 64'(core_clk_enable), 64'h0);
    send(8'h05, 8'h00);
    send(8'h00, 8'h00);
    send(8'h03, 8'h00);
    check("step_c1", 64'(core_clk_enable), 64'h1);
    @(negedge clk); check("step_c2", 64'(core_clk_enable), 64'h1);
    @(negedge clk); check("step_c3", 64'(core_clk_enable), 64'h1);
    @(negedge clk); check("step_done", 64'(core_clk_enable), 64'h0);
    @(negedge clk); check("step_stays_off", 64'(core_clk_enable), 64'h0);

    // N=0 is no step
    send(8'h05, 8'h00);
    send(8'h00, 8'h00);
    send(8'h00, 8'h00);
    check("step_zero", 64'(core_clk_enable), 64'h0);
    send(8'h0A, 8'h00);
    send(8'h03, 8'h00);
    gap(1);
    check("free_run_back", 64'(core_clk_enable), 64'h1);

    // GET_PC with snapshot held while the PC moves
    send(8'h06, 8'h00);
    reg_pc = 64'hFFFF0000FFFF0000;
    for (int i = 0; i < 8; i++) send(8'hA5, pc_val[63-8*i -: 8]);
    send(8'hCC, 8'hCC);
    reg_pc = pc_val;

    // Register read of r3
    send(8'h07, 8'h00);
    send(8'h03, 8'h00);
    check("reg_sel", 64'(reg_read_sel), 64'h3);
    for (int i = 0; i < 8; i++) send(8'h99, (i < 4) ? 8'h00 : 8'(64'hDEADBEEF >> (8*(7-i))));
    send(8'hCC, 8'hCC);

    // Fetched-instruction bundle
    send(8'h09, 8'h00);
    for (int i = 0; i < IB; i++) send(8'h00, 8'(8'h10 + i));
    send(8'h7E, 8'hFF);

    // Reset in the middle of a PC reply
    send(8'h04, 8'h00);
    send(8'h06, 8'h00);
    send(8'h11, 8'h01);
    send(8'h22, 8'h23);
    send(8'h33, 8'h45);
    gap(2);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_clk_en", 64'(core_clk_enable), 64'h1);
    check("midrst_send", 64'(ifc.send_data), 64'h00);
    rst = 1'b0;
    send(8'h7E, 8'hFF);

    gap(4);
    check("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_dbg_engine.md
SPI_DBG_ENGINE -- requirements
Module: spi_dbg_engine

Interface
REQ-001 SHALL have parameter XLEN, default 64, width of the PC and register snapshots (multiple of 8).
REQ-002 SHALL have parameter INSTR_BYTES, default 14, byte length of the fetched-instruction snapshot.
REQ-003 SHALL have parameter REG_SEL_W, default 5, register-select width (1..8).
REQ-004 SHALL have parameter STEP_W, default 16, step-count width (multiple of 8, 8..32).
REQ-005 SHALL have port clk  input  1  single clock for all logic.
REQ-006 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-007 SHALL have port recv_data  input  8  byte received from the SPI slave.
REQ-008 SHALL have port recv_ready  input  1  one-cycle strobe; recv_data is valid.
REQ-009 SHALL have port send_data  output  8  registered byte the SPI slave shifts out on the next transfer.
REQ-010 SHALL have port reg_pc  input  XLEN  core PC.
REQ-011 SHALL have port fetch_instr  input  8*INSTR_BYTES  fetched-instruction bundle.
REQ-012 SHALL have port reg_read_sel  output  REG_SEL_W  core register select, registered.
REQ-013 SHALL have port reg_read_data  input  XLEN  value of the selected register, valid 1 cycle after reg_read_sel changes.
REQ-014 SHALL have port core_clk_enable  output  1  registered clock-gate enable for the core.
REQ-015 SHALL have port led  output  1  debug LED.

Function
REQ-016 SHALL change state, send_data or outputs only in cycles with recv_ready=1, except for step counting and the register-read delay slot.
REQ-017 SHALL use states IDLE, ECHO, REG_SEL, REG_WAIT, STEP_CNT, REPLY.
REQ-018 SHALL, in IDLE, decode recv_data: 0x00 NOP->send 0x00; 0x01 ECHO->send 0x01, go ECHO; 0x02 toggle led, send 0x00; 0x03 enable free-run, send 0x00; 0x04 disable, send 0x00; 0x05 send 0x00, go STEP_CNT; 0x06 snapshot reg_pc, send 0x00, go REPLY with XLEN/8 bytes; 0x07 send 0x00, go REG_SEL; 0x09 snapshot fetch_instr, send 0x00, go REPLY with INSTR_BYTES bytes; 0x0A send status {6'b0, stepping, free_run}; 0xCC send 0xCC; any other byte send 0xFF.
REQ-019 SHALL, in ECHO, send the received byte and return to IDLE.
REQ-020 SHALL, in REG_SEL, register reg_read_sel=recv_data[REG_SEL_W-1:0], send 0x00, go REG_WAIT; next cycle snapshot reg_read_data and go REPLY with XLEN/8 bytes.
REQ-021 SHALL, in STEP_CNT, collect STEP_W/8 bytes MSB first, send 0x00 per byte; after last byte load step counter N and return to IDLE.
REQ-022 SHALL, in REPLY, on each recv_ready send the next snapshot byte MSB first, ignore recv_data as a command, and return to IDLE after the last byte.
REQ-023 SHALL drive core_clk_enable = free_run OR (step counter != 0), registered; counter decrements by 1 per cycle while nonzero, giving exactly N enabled cycles starting the cycle after the last count byte.
REQ-024 SHALL treat N=0 as no step; a new STEP completion overwrites the remaining count.
REQ-025 SHALL, on 0x03, set free_run and clear the counter; on 0x04, clear free_run and the counter.
REQ-026 SHALL take snapshots in the command/select cycle so later core changes do not alter a reply in progress.

Reset
REQ-027 SHALL, on rst asserted at any time, go to IDLE immediately: send_data=0x00, reg_read_sel=0, led=0, free_run=1, step counter=0, core_clk_enable=1, reply/count progress discarded.
REQ-028 SHALL begin decoding with the first recv_ready after rst deasserts.

Verification
REQ-029 Bytes 0x01,0x5A,0x00 -> send_data 0x01, 0x5A, then 0x00.
REQ-030 Bytes 0x04,0x05,0x00,0x03 -> core_clk_enable 0 after 0x04, then high for exactly 3 cycles after last byte, then 0.
REQ-031 reg_pc=0x0123456789ABCDEF, bytes 0x06 then 8 dummies -> 0x00, 0x01,0x23,...,0xEF, back to IDLE (next 0xCC answers 0xCC).
REQ-032 Bytes 0x07,0x03 with reg 3=0xDEADBEEF -> reg_read_sel=3, reply 0x00000000DEADBEEF MSB first.
REQ-033 rst asserted mid GET_PC reply after 3 bytes -> core_clk_enable=1, send_data=0x00; next 0x7E answers 0xFF.
REQ-034 Byte 0x02 twice, then 0x0A -> led 1 then 0, status 0x01.
